phy_mem_ctrl: RTL and testbench
===============================

# phy_mem_ctrl

Physical memory controller sitting directly below the MMU: it receives word-aligned physical requests (address, write data, write strobe) and drives one external asynchronous 32-bit SRAM. Reads are zero-wait combinational by default, so instruction fetch completes in the same cycle. Writes, and reads with configured wait states, are multi-cycle: busy is asserted before the next clock edge and address/data are latched internally.

## Interface
- ADDR_WIDTH, 20: SRAM word-address width; capacity is 2^ADDR_WIDTH words.
- READ_WAIT, 0: extra read wait cycles, 0..15. 0 selects a purely combinational read path.
- WRITE_CYCLES, 2: cycles sram_we_n is held low, 1..15.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  32  physical byte address; bits [1:0] ignored.
- mem_data_wr  in  32  write data, sampled on the posedge where mem_is_write=1 in IDLE.
- mem_is_write  in  1  one-cycle write strobe.
- mem_data_rd  out  32  read data.
- mem_busy  out  1  access in progress; combinational from state and inputs.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_dq_i  in  32  SRAM data in.
- sram_dq_o  out  32  SRAM data out.
- sram_dq_oe  out  1  data-bus drive enable for the top-level tristate.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM controls, active low.

## Operation
- In range: mem_addr[31:ADDR_WIDTH+2]==0. Out of range:
  - reads return 32'h0;
  - writes are dropped;
  - mem_busy stays 0;
  - SRAM is deselected (ce_n=1).
- States: IDLE, RD_WAIT, RD_DONE, WR_PULSE, WR_HOLD. A 4-bit counter cnt is used for RD_WAIT and WR_PULSE.
- IDLE, no write, in range, READ_WAIT=0:
  - sram_addr = mem_addr[ADDR_WIDTH+1:2]; ce_n=0, oe_n=0, we_n=1, dq_oe=0;
  - mem_data_rd = sram_dq_i; mem_busy=0; state holds.
- IDLE, no write, in range, READ_WAIT>0:
  - mem_busy=1 combinationally; address latched; cnt<=1.
  - Next state RD_WAIT.
- RD_WAIT:
  - Drives the latched address; ce_n=0, oe_n=0; mem_busy=1.
  - When cnt==READ_WAIT: rd_reg<=sram_dq_i, go to RD_DONE. Otherwise cnt++.
- RD_DONE:
  - mem_busy=0; mem_data_rd=rd_reg; SRAM deselected.
  - Inputs ignored; next state IDLE.
- IDLE with mem_is_write=1, in range:
  - mem_busy=1 combinationally; no SRAM write this cycle (ce_n=1).
  - Latch address and mem_data_wr; cnt<=1; next state WR_PULSE.
- WR_PULSE:
  - ce_n=0, we_n=0, oe_n=1, dq_oe=1; sram_dq_o = latched data; mem_busy=1.
  - When cnt==WRITE_CYCLES, go to WR_HOLD. Otherwise cnt++.
- WR_HOLD:
  - we_n=1; ce_n, dq_oe and address/data held; mem_busy=1.
  - Next state IDLE.
- mem_is_write asserted outside IDLE is ignored and not queued; the bench flags it as a protocol error.
- dq_oe is 1 only in WR_PULSE and WR_HOLD; oe_n is 0 only during reads. This guarantees no bus contention.

## Timing
- Reset (async, immediate on rst_n low):
  - state=IDLE, cnt=0, rd_reg=0, latched address/data=0;
  - sram_we_n=1, sram_dq_oe=0.
  - While rst_n=0: ce_n=1, oe_n=1, mem_busy=0, mem_data_rd=0.
- Read, READ_WAIT=0: data valid in the same cycle as the request, zero latency.
- Read, READ_WAIT=N:
  - mem_busy high for N+1 cycles (request cycle plus N wait cycles);
  - data presented in RD_DONE, cycle N+1 after the request cycle.
- Write, WRITE_CYCLES=W:
  - mem_busy high for W+2 cycles (strobe cycle, W pulse cycles, 1 hold cycle);
  - next access is accepted in the following IDLE cycle.
- Reset mid-write: we_n rises and dq_oe drops asynchronously; the write is abandoned.
- Reset mid-read: the read is abandoned; mem_data_rd=0.
- Address wrap: none. The top address (2^ADDR_WIDTH-1)*4 is in range; the next word is out of range.

## Test plan
- READ_WAIT=0:
  - Preload word 0x12345 with 0xDEADBEEF; present mem_addr=0x00048D14.
  - Required: same cycle mem_data_rd=0xDEADBEEF, mem_busy=0, sram_addr=0x12345.
- WRITE_CYCLES=2:
  - Pulse mem_is_write with addr 0x10, data 0xCAFEF00D.
  - Required: busy high exactly 4 cycles; we_n low exactly 2 cycles with sram_addr=4 and dq_o=0xCAFEF00D.
  - A subsequent read of 0x10 returns 0xCAFEF00D.
- READ_WAIT=3:
  - Read addr 0x20 holding 0x55AA55AA.
  - Required: busy high 4 cycles, then one cycle busy=0 with mem_data_rd=0x55AA55AA.
- Out of range:
  - Read 0x00400000 (ADDR_WIDTH=20). Required: mem_data_rd=0, busy=0, ce_n=1.
  - Write to 0x80000000. Required: no we_n pulse, busy=0.
- Reset mid-write: drop rst_n in the 2nd WR_PULSE cycle. Required: we_n=1 and dq_oe=0 before the next posedge; state IDLE after release.
- Protocol checks:
  - Back-to-back write then read with mem_is_write re-asserted during WR_HOLD. Required: the strobe is ignored, only one write occurs, and oe_n and dq_oe are never both active.

Source files
------------

// File: rtl/phy_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phy_mem_ctrl
// Purpose  : Physical memory controller driving one asynchronous 32-bit SRAM.
//            Zero-wait combinational reads when READ_WAIT == 0, otherwise
//            multi-cycle latched reads. Writes are always multi-cycle with a
//            WRITE_CYCLES-long we_n pulse followed by one hold cycle.
// Revision : 1.0  initial release
// ============================================================================
module phy_mem_ctrl #(
  parameter int ADDR_WIDTH   = 20,
  parameter int READ_WAIT    = 0,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           i_mem_addr,
  input  logic [31:0]           i_mem_data_wr,
  input  logic                  i_mem_is_write,
  output logic [31:0]           o_mem_data_rd,
  output logic                  o_mem_busy,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [31:0]           i_sram_dq_i,
  output logic [31:0]           o_sram_dq_o,
  output logic                  o_sram_dq_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  localparam logic [3:0] c_READ_WAIT    = 4'(READ_WAIT);
  localparam logic [3:0] c_WRITE_CYCLES = 4'(WRITE_CYCLES);
  localparam bit         c_RD_COMB      = (READ_WAIT == 0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rd_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_start_wr;
  logic                  w_start_rd;
  logic                  w_rd_capture;
  logic                  w_cnt_inc;
  logic                  w_unused_low_bits;

  // Byte-offset bits carry no meaning for word-aligned requests.
  assign w_unused_low_bits = ^i_mem_addr[1:0];
  // Any address bit above the SRAM word range makes the request out of range.
  assign w_in_range = ((i_mem_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_word     = i_mem_addr[ADDR_WIDTH+1:2];

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latched address/data, wait counter and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_rd_data <= 32'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
    end else begin
      if (w_start_wr) begin
        r_addr  <= w_word;
        r_wdata <= i_mem_data_wr;
        r_cnt   <= 4'd1;
      end else if (w_start_rd) begin
        r_addr <= w_word;
        r_cnt  <= 4'd1;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_rd_capture) begin
        r_rd_data <= i_sram_dq_i;
      end
    end
  end

  // Next-state and SRAM/host outputs; everything inactive while in reset.
  always_comb begin
    w_next_state  = r_state;
    w_start_wr    = 1'b0;
    w_start_rd    = 1'b0;
    w_rd_capture  = 1'b0;
    w_cnt_inc     = 1'b0;
    o_mem_busy    = 1'b0;
    o_mem_data_rd = 32'd0;
    o_sram_addr   = r_addr;
    o_sram_dq_o   = r_wdata;
    o_sram_dq_oe  = 1'b0;
    o_sram_ce_n   = 1'b1;
    o_sram_oe_n   = 1'b1;
    o_sram_we_n   = 1'b1;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          o_sram_addr = w_word;
          if (w_in_range) begin
            if (i_mem_is_write) begin
              // Strobe cycle only latches; the SRAM stays deselected.
              o_mem_busy   = 1'b1;
              w_start_wr   = 1'b1;
              w_next_state = ST_WR_PULSE;
            end else if (c_RD_COMB) begin
              o_sram_ce_n   = 1'b0;
              o_sram_oe_n   = 1'b0;
              o_mem_data_rd = i_sram_dq_i;
            end else begin
              o_sram_ce_n  = 1'b0;
              o_sram_oe_n  = 1'b0;
              o_mem_busy   = 1'b1;
              w_start_rd   = 1'b1;
              w_next_state = ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          o_sram_ce_n = 1'b0;
          o_sram_oe_n = 1'b0;
          o_mem_busy  = 1'b1;
          if (r_cnt == c_READ_WAIT) begin
            w_rd_capture = 1'b1;
            w_next_state = ST_RD_DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_RD_DONE: begin
          o_mem_data_rd = r_rd_data;
          w_next_state  = ST_IDLE;
        end
        ST_WR_PULSE: begin
          o_sram_ce_n  = 1'b0;
          o_sram_we_n  = 1'b0;
          o_sram_dq_oe = 1'b1;
          o_mem_busy   = 1'b1;
          if (r_cnt == c_WRITE_CYCLES) begin
            w_next_state = ST_WR_HOLD;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_WR_HOLD: begin
          // we_n has risen; keep the bus driven one more cycle for hold time.
          o_sram_ce_n  = 1'b0;
          o_sram_dq_oe = 1'b1;
          o_mem_busy   = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_mem_ctrl
// Purpose  : Self-checking bench for phy_mem_ctrl. Two instances (zero-wait
//            reads and 3-wait reads) each with an SRAM model; results are
//            compared with a word-level reference memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_phy_mem_ctrl;

  localparam int          AW     = 20;
  localparam int          WC     = 2;
  localparam int          RW1    = 3;
  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][31:0]   addr;
  logic [1:0][31:0]   wdata;
  logic [1:0]         is_wr;
  logic [1:0][31:0]   rd;
  logic [1:0]         busy;
  logic [1:0][AW-1:0] saddr;
  logic [1:0][31:0]   dqi;
  logic [1:0][31:0]   dqo;
  logic [1:0]         dqoe;
  logic [1:0]         ce_n;
  logic [1:0]         oe_n;
  logic [1:0]         we_n;

  int errors = 0;
  int checks = 0;

  phy_mem_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(0), .WRITE_CYCLES(WC)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(addr[0]), .i_mem_data_wr(wdata[0]), .i_mem_is_write(is_wr[0]),
    .o_mem_data_rd(rd[0]), .o_mem_busy(busy[0]), .o_sram_addr(saddr[0]),
    .i_sram_dq_i(dqi[0]), .o_sram_dq_o(dqo[0]), .o_sram_dq_oe(dqoe[0]),
    .o_sram_ce_n(ce_n[0]), .o_sram_oe_n(oe_n[0]), .o_sram_we_n(we_n[0])
  );

  phy_mem_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(RW1), .WRITE_CYCLES(WC)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(addr[1]), .i_mem_data_wr(wdata[1]), .i_mem_is_write(is_wr[1]),
    .o_mem_data_rd(rd[1]), .o_mem_busy(busy[1]), .o_sram_addr(saddr[1]),
    .i_sram_dq_i(dqi[1]), .o_sram_dq_o(dqo[1]), .o_sram_dq_oe(dqoe[1]),
    .o_sram_ce_n(ce_n[1]), .o_sram_oe_n(oe_n[1]), .o_sram_we_n(we_n[1])
  );

  // SRAM models with a backdoor preload port.
  logic [31:0]   sram0 [0:(1<<AW)-1];
  logic [31:0]   sram1 [0:(1<<AW)-1];
  logic [1:0]    pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  assign dqi[0] = sram0[saddr[0]];
  assign dqi[1] = sram1[saddr[1]];

  always @(posedge clk) begin
    if (pl_en[0]) sram0[pl_addr] <= pl_data;
    else if (!ce_n[0] && !we_n[0]) sram0[saddr[0]] <= dqo[0];
    if (pl_en[1]) sram1[pl_addr] <= pl_data;
    else if (!ce_n[1] && !we_n[1]) sram1[saddr[1]] <= dqo[1];
  end

  // Bus monitor: contention check and write-pulse bookkeeping.
  int          we_cnt  [2];
  logic [31:0] we_addr [2];
  logic [31:0] we_data [2];
  initial begin
    we_cnt = '{0, 0};
    we_addr = '{32'd0, 32'd0};
    we_data = '{32'd0, 32'd0};
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        checks++;
        assert (!(!oe_n[k] && dqoe[k])) else begin
          errors++;
          $error("FAIL contention dut%0d: oe_n=%b dq_oe=%b, required not both active", k, oe_n[k], dqoe[k]);
        end
      end
      if (!we_n[k]) begin
        we_cnt[k]++;
        we_addr[k] = {{(32-AW){1'b0}}, saddr[k]};
        we_data[k] = dqo[k];
      end
    end
  end

  // Reference model: word-addressed memories and the timing rules.
  logic [31:0] ref0 [int];
  logic [31:0] ref1 [int];
  int          rw_of [2] = '{0, RW1};

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic bit ref_known(input int s, input logic [31:0] a);
    int w;
    if (!in_rng(a)) return 1'b1;
    w = int'(a[AW+1:2]);
    return (s == 0) ? ref0.exists(w) : ref1.exists(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int s, input logic [31:0] a);
    int w;
    if (!in_rng(a)) return 32'd0;
    w = int'(a[AW+1:2]);
    if (s == 0) return ref0.exists(w) ? ref0[w] : 32'd0;
    return ref1.exists(w) ? ref1[w] : 32'd0;
  endfunction

  task automatic ref_wr(input int s, input logic [31:0] a, input logic [31:0] d);
    if (in_rng(a)) begin
      if (s == 0) ref0[int'(a[AW+1:2])] = d;
      else        ref1[int'(a[AW+1:2])] = d;
    end
  endtask

  function automatic int exp_busy(input int s, input bit wr, input logic [31:0] a);
    if (!in_rng(a)) return 0;
    if (wr) return WC + 2;
    return (rw_of[s] == 0) ? 0 : rw_of[s] + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int s, input int w, input logic [31:0] d);
    pl_en[s] = 1'b1;
    pl_addr  = AW'(w);
    pl_data  = d;
    @(posedge clk); #1;
    pl_en = 2'b00;
    if (s == 0) ref0[w] = d;
    else        ref1[w] = d;
  endtask

  // One complete access; returns data from the first non-busy cycle and the
  // number of busy cycles. Called and returns at posedge+1.
  task automatic access(input int s, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdat,
                        output int bcyc);
    bit tmo;
    addr[s] = a; wdata[s] = d; is_wr[s] = wr;
    bcyc = 0; rdat = 32'd0; tmo = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy[s]) begin
        rdat = rd[s];
        break;
      end
      bcyc++;
      if (bcyc > 40) begin
        tmo = 1'b1;
        break;
      end
      @(posedge clk); #1;
      is_wr[s] = 1'b0; addr[s] = IDLE_A;
    end
    if (tmo) begin
      checks++;
      errors++;
      $error("FAIL timeout dut%0d: busy cycles=%0d, required completion within 40", s, bcyc);
    end
    @(posedge clk); #1;
    is_wr[s] = 1'b0; addr[s] = IDLE_A;
  endtask

  initial begin
    logic [31:0] r;
    int          b;
    int          w0;
    addr  = {IDLE_A, IDLE_A};
    wdata = '0;
    is_wr = '0;
    pl_en = '0; pl_addr = '0; pl_data = '0;

    // Reset state, with an in-range read presented to the zero-wait instance.
    addr[0] = 32'h0000_0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_ce_n", ce_n[0], 1);
    chk("rst_oe_n", oe_n[0], 1);
    chk("rst_we_n", we_n[0], 1);
    chk("rst_dq_oe", dqoe[0], 0);
    chk("rst_rd", rd[0], 0);
    chk("rst_busy1", busy[1], 0);
    addr[0] = IDLE_A;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read, same-cycle data.
    preload(0, 'h12345, 32'hDEAD_BEEF);
    addr[0] = 32'h0004_8D14;
    @(negedge clk);
    chk("zw_rd", rd[0], 32'hDEAD_BEEF);
    chk("zw_busy", busy[0], 0);
    chk("zw_saddr", saddr[0], 32'h12345);
    chk("zw_ce_n", ce_n[0], 0);
    @(posedge clk); #1 addr[0] = IDLE_A;

    // Write, WRITE_CYCLES=2, then read back.
    w0 = we_cnt[0];
    access(0, 1'b1, 32'h10, 32'hCAFE_F00D, r, b);
    ref_wr(0, 32'h10, 32'hCAFE_F00D);
    chk("wr_busy_cycles", b, WC + 2);
    chk("wr_we_cycles", we_cnt[0] - w0, WC);
    chk("wr_pulse_addr", we_addr[0], 32'd4);
    chk("wr_pulse_data", we_data[0], 32'hCAFE_F00D);
    access(0, 1'b0, 32'h10, 32'd0, r, b);
    chk("wr_readback", r, ref_rd(0, 32'h10));
    chk("wr_readback_busy", b, 0);

    // Read with three wait states.
    preload(1, 8, 32'h55AA_55AA);
    access(1, 1'b0, 32'h20, 32'd0, r, b);
    chk("rw3_busy_cycles", b, RW1 + 1);
    chk("rw3_data", r, 32'h55AA_55AA);

    // Out-of-range read and write.
    addr[0] = 32'h0040_0000;
    @(negedge clk);
    chk("oor_rd", rd[0], 0);
    chk("oor_busy", busy[0], 0);
    chk("oor_ce_n", ce_n[0], 1);
    @(posedge clk); #1 addr[0] = IDLE_A;
    w0 = we_cnt[0];
    access(0, 1'b1, 32'h8000_0000, 32'h1234_5678, r, b);
    chk("oor_wr_busy", b, 0);
    chk("oor_wr_we", we_cnt[0] - w0, 0);
    access(1, 1'b0, 32'h0040_0000, 32'd0, r, b);
    chk("oor_rd1_busy", b, 0);
    chk("oor_rd1_data", r, 0);

    // Topmost word is in range.
    access(1, 1'b1, 32'h003F_FFFC, 32'h0F1E_2D3C, r, b);
    ref_wr(1, 32'h003F_FFFC, 32'h0F1E_2D3C);
    chk("top_wr_busy", b, WC + 2);
    access(1, 1'b0, 32'h003F_FFFC, 32'd0, r, b);
    chk("top_rd_data", r, ref_rd(1, 32'h003F_FFFC));

    // Reset during the second write-pulse cycle.
    addr[0] = 32'h40; wdata[0] = 32'h1111_2222; is_wr[0] = 1'b1;
    @(posedge clk); #1;
    is_wr[0] = 1'b0; addr[0] = IDLE_A;
    @(posedge clk); #2;
    chk("rstw_we_low_before", we_n[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_n", we_n[0], 1);
    chk("rstw_dq_oe", dqoe[0], 0);
    chk("rstw_busy", busy[0], 0);
    chk("rstw_ce_n", ce_n[0], 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 32'h10, 32'd0, r, b);
    chk("rstw_idle_busy", b, 0);
    chk("rstw_idle_rd", r, ref_rd(0, 32'h10));

    // Reset during a wait-state read.
    addr[1] = 32'h20;
    @(posedge clk); #1 addr[1] = IDLE_A;
    #2 rst_n = 1'b0;
    #1;
    chk("rstr_rd", rd[1], 0);
    chk("rstr_busy", busy[1], 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 32'h20, 32'd0, r, b);
    chk("rstr_again_busy", b, RW1 + 1);
    chk("rstr_again_data", r, ref_rd(1, 32'h20));

    // Write strobe re-asserted during WR_HOLD, then back-to-back read.
    preload(0, 'h41, 32'h1357_9BDF);
    w0 = we_cnt[0];
    addr[0] = 32'h100; wdata[0] = 32'hA5A5_0001; is_wr[0] = 1'b1;
    @(posedge clk); #1;
    is_wr[0] = 1'b0; addr[0] = IDLE_A;
    @(posedge clk);
    @(posedge clk); #1;
    addr[0] = 32'h104; wdata[0] = 32'hBAD0_BAD0; is_wr[0] = 1'b1;
    @(negedge clk);
    chk("proto_hold_busy", busy[0], 1);
    @(posedge clk); #1;
    is_wr[0] = 1'b0; addr[0] = 32'h100;
    ref_wr(0, 32'h100, 32'hA5A5_0001);
    @(negedge clk);
    chk("proto_b2b_rd", rd[0], ref_rd(0, 32'h100));
    chk("proto_b2b_busy", busy[0], 0);
    @(posedge clk); #1 addr[0] = IDLE_A;
    chk("proto_one_write", we_cnt[0] - w0, WC);
    access(0, 1'b0, 32'h104, 32'd0, r, b);
    chk("proto_ignored_rd", r, ref_rd(0, 32'h104));

    // Randomized traffic against the reference memory.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) preload(s, w, $urandom);
      preload(s, (1 << AW) - 1, $urandom);
    end
    for (int n = 0; n < 80; n++) begin
      int          s;
      int          kind;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      s    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      d    = $urandom;
      wr   = (kind <= 3) || (kind == 8);
      if (kind <= 7) begin
        a = {10'd0, ($urandom_range(0, 15) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      end else begin
        a = $urandom;
        if ((a >> (AW + 2)) == 32'd0) a[31] = 1'b1;
      end
      w0 = we_cnt[s];
      access(s, wr, a, d, r, b);
      chk($sformatf("rnd%0d_busy", n), b, exp_busy(s, wr, a));
      chk($sformatf("rnd%0d_we", n), we_cnt[s] - w0, (wr && in_rng(a)) ? WC : 0);
      if (wr) begin
        ref_wr(s, a, d);
      end else if (ref_known(s, a)) begin
        chk($sformatf("rnd%0d_data", n), r, ref_rd(s, a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
